// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner: SCAN_DIV-cycle SHOW slot per digit, then a 1-cycle dark GAP.
// Outputs are registered (one edge behind inputs); digit writes are accepted only in IDLE/GAP.
module seg_scan_ctrl #(
    parameter int SCAN_DIV = 4
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       en,
    input  logic       wr_valid,
    input  logic [1:0] wr_idx,
    input  logic [3:0] wr_data,
    output logic       wr_ready,
    input  logic [3:0] blank_mask,
    output logic [3:0] seg_data,
    output logic [3:0] dig_sel,
    output logic       frame_done
);

    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

    localparam logic [7:0] LAST_CNT = 8'(SCAN_DIV - 1);

    state_t     state;
    logic [1:0] idx;
    logic [1:0] idx_nxt;
    logic [7:0] slot_cnt;
    logic [3:0] d      [4];
    logic [3:0] d_next [4];
    logic       wr_acc;

    assign wr_acc  = wr_valid & wr_ready;
    assign idx_nxt = idx + 2'd1;

    // Slot entry reads d_next so a write accepted on the entry edge lands immediately.
    always_comb begin
        for (int i = 0; i < 4; i++) d_next[i] = d[i];
        if (wr_acc) d_next[wr_idx] = wr_data;
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= 2'd0;
            slot_cnt   <= 8'd0;
            dig_sel    <= 4'b0000;
            seg_data   <= 4'd0;
            frame_done <= 1'b0;
            wr_ready   <= 1'b1;
            for (int i = 0; i < 4; i++) d[i] <= 4'd0;
        end else begin
            for (int i = 0; i < 4; i++) d[i] <= d_next[i];
            if (!en) begin
                state      <= IDLE;
                idx        <= 2'd0;
                slot_cnt   <= 8'd0;
                dig_sel    <= 4'b0000;
                seg_data   <= 4'd0;
                frame_done <= 1'b0;
                wr_ready   <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        state      <= SHOW;
                        idx        <= 2'd0;
                        slot_cnt   <= 8'd0;
                        seg_data   <= d_next[0];
                        dig_sel    <= blank_mask[0] ? 4'b0000 : 4'b0001;
                        frame_done <= 1'b0;
                        wr_ready   <= 1'b0;
                    end
                    SHOW: begin
                        if (slot_cnt == LAST_CNT) begin
                            state      <= GAP;
                            dig_sel    <= 4'b0000;
                            seg_data   <= 4'd0;
                            frame_done <= (idx == 2'd3);
                            wr_ready   <= 1'b1;
                        end else begin
                            slot_cnt <= slot_cnt + 8'd1;
                            seg_data <= d[idx];
                            dig_sel  <= blank_mask[idx] ? 4'b0000 : (4'b0001 << idx);
                        end
                    end
                    GAP: begin
                        state      <= SHOW;
                        idx        <= idx_nxt;
                        slot_cnt   <= 8'd0;
                        seg_data   <= d_next[idx_nxt];
                        dig_sel    <= blank_mask[idx_nxt] ? 4'b0000 : (4'b0001 << idx_nxt);
                        frame_done <= 1'b0;
                        wr_ready   <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4, meaning the number of CLK cycles each digit is driven per slot; legal range 1..255.
REQ-002 SHALL have port CLK  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port en  input  1  scan enable; 1 = run scan, 0 = idle/dark.
REQ-005 SHALL have port wr_valid  input  1  digit-write request.
REQ-006 SHALL have port wr_idx  input  2  target digit index 0..3.
REQ-007 SHALL have port wr_data  input  4  BCD/hex value for target digit.
REQ-008 SHALL have port wr_ready  output  1  write accepted this cycle when wr_valid & wr_ready.
REQ-009 SHALL have port blank_mask  input  4  bit i = 1 forces digit i dark; sampled every cycle.
REQ-010 SHALL have port seg_data  output  4  value presented to the shared 7-segment decoder.
REQ-011 SHALL have port dig_sel  output  4  one-hot digit enable, active-high; bit i drives digit i.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse at end of each full 4-digit frame.

Function
REQ-013 SHALL hold four 4-bit digit registers d[0..3] and a 2-bit scan index idx.
REQ-014 SHALL implement FSM states IDLE, SHOW, GAP; all outputs registered.
REQ-015 IDLE: dig_sel=0, seg_data=0, idx=0; transition to SHOW(idx=0) on the edge where en=1.
REQ-016 SHOW: lasts exactly SCAN_DIV cycles; seg_data=d[idx]; dig_sel=one-hot(idx) unless blank_mask[idx]=1, then dig_sel=0.
REQ-017 GAP: exactly 1 cycle, dig_sel=0, seg_data=0 (anti-ghost interval); on exit idx <= idx+1 mod 4 and state <= SHOW.
REQ-018 Slot timing SHALL be SCAN_DIV+1 cycles per digit and 4*(SCAN_DIV+1) cycles per frame, independent of blank_mask.
REQ-019 frame_done SHALL pulse high for exactly the single GAP cycle following digit 3's SHOW; 0 otherwise.
REQ-020 idx SHALL wrap 3 -> 0 without skipping or repeating a digit.
REQ-021 en=0 in any state SHALL move to IDLE on the next edge (abandon the current slot; no frame_done); re-enable restarts at digit 0.
REQ-022 wr_ready SHALL be 1 in IDLE and GAP, 0 in SHOW; a write never changes the digit being driven mid-slot.
REQ-023 Accepted write SHALL update d[wr_idx] on that edge; value visible at that digit's next SHOW slot.
REQ-024 wr_valid while wr_ready=0 SHALL be ignored; requester holds wr_valid until accepted.
REQ-025 Slot counter SHALL be 8 bits, cleared on entry to SHOW, compared against SCAN_DIV-1.
REQ-026 blank_mask change during SHOW SHALL take effect on the next edge.

Reset
REQ-027 rst=1 at an edge SHALL force state=IDLE, idx=0, slot counter=0, d[0..3]=0, dig_sel=0, seg_data=0, frame_done=0, wr_ready=1 (IDLE value).
REQ-028 rst SHALL take priority over en and wr_valid; a write presented in the reset cycle SHALL be dropped.
REQ-029 Reset mid-frame SHALL drop dig_sel to 0 on the next edge with no frame_done pulse.

Verification
REQ-030 Reset, write d=1,2,3,4 in IDLE, en=1, SCAN_DIV=4 -> dig_sel 0001 x4 cycles, 0000 x1, 0010 x4, ... seg_data 1,0,2,0,3,0,4,0; frame_done high on cycle 20 only.
REQ-031 Run with blank_mask=0100 -> digit 2 slot shows dig_sel=0000 for 4 cycles, frame period still 20 cycles.
REQ-032 wr_valid held with wr_idx=1, wr_data=9 asserted in SHOW -> wr_ready=0 until next GAP, accepted there, digit 1 shows 9 on its next slot.
REQ-033 Deassert en during digit 2 SHOW -> IDLE next edge, dig_sel=0, no frame_done; re-enable -> digit 0 first.
REQ-034 Assert rst during digit 3 -> all outputs at reset values next edge, d registers read 0 after re-enable.
REQ-035 SCAN_DIV=1 build -> 2-cycle slots, 8-cycle frame, idx wraps 3->0 correctly over 3 frames.
